// File: rtl/viewport_pkg.sv
// rtl/viewport_pkg.sv - frame states, key indices and saturating arithmetic for viewport_ctrl
package viewport_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    UPDATE = 2'd1,
    BLANK  = 2'd2
  } frame_state_e;

  localparam int K_UP     = 0;
  localparam int K_DOWN   = 1;
  localparam int K_LEFT   = 2;
  localparam int K_RIGHT  = 3;
  localparam int K_ZIN    = 4;
  localparam int K_ZOUT   = 5;
  localparam int NUM_KEYS = 6;

  // Wide enough that val + delta never overflows before the clamp is applied.
  function automatic logic [31:0] sat_addsub(
    input logic [31:0] val,
    input logic [31:0] delta,
    input logic        sub,
    input logic [31:0] max_val
  );
    logic [31:0] res;
    if (sub) begin
      res = (val > delta) ? (val - delta) : 32'd0;
    end else begin
      res = val + delta;
      if (res > max_val) res = max_val;
    end
    return res;
  endfunction

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - per-key frame-rate auto-repeat: fire on first held frame,
// pause, then fire every frame once the held count saturates at REPEAT_DELAY.
module key_repeat #(
  parameter int REPEAT_DELAY = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  input  logic frame_tick,
  output logic fire
);

  localparam int CW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;
  localparam logic [CW-1:0] DELAY = CW'(REPEAT_DELAY);

  logic [CW-1:0] held_cnt;

  assign fire = frame_tick && !key_n && ((held_cnt == '0) || (held_cnt == DELAY));

  always_ff @(posedge CLK) begin
    if (RST) begin
      held_cnt <= '0;
    end else if (frame_tick) begin
      if (key_n) begin
        held_cnt <= '0;
      end else if (held_cnt != DELAY) begin
        held_cnt <= held_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/viewport_ctrl.sv
// rtl/viewport_ctrl.sv - pan/zoom viewport between sync generator and pixel generator;
// origin and zoom move once per vertical blank, colour is registered with blanking.
module viewport_ctrl
  import viewport_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int COLOR_BITS   = 1,
  parameter int STEP         = 2,
  parameter int X_INIT       = 300,
  parameter int Y_INIT       = 200,
  parameter int X_MAX        = 639,
  parameter int Y_MAX        = 479,
  parameter int ZOOM_MAX     = 3,
  parameter int REPEAT_DELAY = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [COORD_W-1:0]                 row,
  input  logic [COORD_W-1:0]                 col,
  input  logic                               vnotactive,
  input  logic                               up,
  input  logic                               down,
  input  logic                               left,
  input  logic                               right,
  input  logic                               zoom_in,
  input  logic                               zoom_out,
  input  logic [3*COLOR_BITS-1:0]            pix_in,
  output logic [COORD_W-1:0]                 map_x,
  output logic [COORD_W-1:0]                 map_y,
  output logic [COORD_W-1:0]                 originX,
  output logic [COORD_W-1:0]                 originY,
  output logic [$clog2(ZOOM_MAX+1)-1:0]      zoom,
  output logic [COLOR_BITS-1:0]              red,
  output logic [COLOR_BITS-1:0]              green,
  output logic [COLOR_BITS-1:0]              blue
);

  localparam int ZW = $clog2(ZOOM_MAX + 1);
  localparam logic [ZW-1:0] ZOOM_TOP = ZW'(ZOOM_MAX);

  frame_state_e          state;
  logic                  frame_tick;
  logic [NUM_KEYS-1:0]   key_n;
  logic [NUM_KEYS-1:0]   fire;
  logic [31:0]           pan_step;
  logic [COORD_W-1:0]    next_x;
  logic [COORD_W-1:0]    next_y;
  logic [ZW-1:0]         next_zoom;

  // One UPDATE cycle per blanking interval, however long vnotactive stays high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ACTIVE;
    end else begin
      case (state)
        ACTIVE:  if (vnotactive) state <= UPDATE;
        UPDATE:  state <= BLANK;
        BLANK:   if (!vnotactive) state <= ACTIVE;
        default: state <= ACTIVE;
      endcase
    end
  end

  assign frame_tick = (state == UPDATE);

  assign key_n[K_UP]    = up;
  assign key_n[K_DOWN]  = down;
  assign key_n[K_LEFT]  = left;
  assign key_n[K_RIGHT] = right;
  assign key_n[K_ZIN]   = zoom_in;
  assign key_n[K_ZOUT]  = zoom_out;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_repeat #(
      .REPEAT_DELAY(REPEAT_DELAY)
    ) u_key_repeat (
      .CLK       (CLK),
      .RST       (RST),
      .key_n     (key_n[k]),
      .frame_tick(frame_tick),
      .fire      (fire[k])
    );
  end

  // Pan distance scales with the zoom in force before this update.
  assign pan_step = 32'(STEP) << zoom;

  always_comb begin
    next_x    = originX;
    next_y    = originY;
    next_zoom = zoom;

    if (fire[K_UP]) begin
      next_y = COORD_W'(sat_addsub(32'(originY), pan_step, 1'b1, 32'(Y_MAX)));
    end else if (fire[K_DOWN]) begin
      next_y = COORD_W'(sat_addsub(32'(originY), pan_step, 1'b0, 32'(Y_MAX)));
    end

    if (fire[K_LEFT]) begin
      next_x = COORD_W'(sat_addsub(32'(originX), pan_step, 1'b1, 32'(X_MAX)));
    end else if (fire[K_RIGHT]) begin
      next_x = COORD_W'(sat_addsub(32'(originX), pan_step, 1'b0, 32'(X_MAX)));
    end

    if (fire[K_ZIN]) begin
      if (zoom != ZOOM_TOP) next_zoom = zoom + 1'b1;
    end else if (fire[K_ZOUT]) begin
      if (zoom != '0) next_zoom = zoom - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      originX <= COORD_W'(X_INIT);
      originY <= COORD_W'(Y_INIT);
      zoom    <= '0;
    end else if (frame_tick) begin
      originX <= next_x;
      originY <= next_y;
      zoom    <= next_zoom;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      map_x              <= '0;
      map_y              <= '0;
      {red, green, blue} <= '1;
    end else begin
      map_x              <= originX + (col >> zoom);
      map_y              <= originY + (row >> zoom);
      {red, green, blue} <= vnotactive ? '0 : pix_in;
    end
  end

endmodule

// File: tb/tb_viewport_ctrl.sv
// tb/tb_viewport_ctrl.sv - scoreboard bench for viewport_ctrl: reset, pan, repeat,
// clamping, priority, mapping pipeline and reset during UPDATE.
`timescale 1ns/1ps
module tb_viewport_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [9:0] row, col;
  logic       vnotactive;
  logic       up, down, left, right, zoom_in, zoom_out;
  logic [2:0] pix_in;
  logic [9:0] map_x, map_y, originX, originY;
  logic [1:0] zoom;
  logic       red, green, blue;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0] mx;
    logic [9:0] my;
    logic [2:0] rgb;
  } exp_t;
  exp_t exp_q[$];

  viewport_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .row       (row),
    .col       (col),
    .vnotactive(vnotactive),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .zoom_in   (zoom_in),
    .zoom_out  (zoom_out),
    .pix_in    (pix_in),
    .map_x     (map_x),
    .map_y     (map_y),
    .originX   (originX),
    .originY   (originY),
    .zoom      (zoom),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  always #5 CLK = ~CLK;

  // mask bits: 0 up, 1 down, 2 left, 3 right, 4 zoom_in, 5 zoom_out (set = pressed)
  task automatic set_keys(input logic [5:0] mask);
    up = ~mask[0]; down = ~mask[1]; left = ~mask[2];
    right = ~mask[3]; zoom_in = ~mask[4]; zoom_out = ~mask[5];
  endtask

  task automatic run_frame(input int blank_len, input int act_len);
    vnotactive = 1'b1;
    repeat (blank_len) @(negedge CLK);
    vnotactive = 1'b0;
    repeat (act_len) @(negedge CLK);
  endtask

  task automatic tap(input logic [5:0] mask);
    set_keys(mask);
    run_frame(3, 3);
    set_keys(6'b0);
    run_frame(3, 3);
  endtask

  task automatic do_reset();
    RST = 1'b1; set_keys(6'b0); vnotactive = 1'b0;
    col = '0; row = '0; pix_in = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; set_keys(6'b0); vnotactive = 1'b0;
    col = 10'd5; row = 10'd5; pix_in = 3'b010;
    repeat (3) @(negedge CLK);
    checks++; if (originX !== 10'd300) begin errors++; $display("FAIL reset_originX got %0d exp 300", originX); end
    checks++; if (originY !== 10'd200) begin errors++; $display("FAIL reset_originY got %0d exp 200", originY); end
    checks++; if (zoom !== 2'd0) begin errors++; $display("FAIL reset_zoom got %0d exp 0", zoom); end
    checks++; if ({map_x, map_y} !== 20'd0) begin errors++; $display("FAIL reset_map got %0d,%0d exp 0,0", map_x, map_y); end
    RST = 1'b0;
    checks++; if ({red, green, blue} !== 3'b111) begin errors++; $display("FAIL reset_rgb got %b exp 111", {red, green, blue}); end
    repeat (3) run_frame(4, 4);
    checks++; if (originX !== 10'd300 || originY !== 10'd200) begin errors++; $display("FAIL idle_origin got %0d,%0d exp 300,200", originX, originY); end
    checks++; if (zoom !== 2'd0) begin errors++; $display("FAIL idle_zoom got %0d exp 0", zoom); end
    checks++; if ({red, green, blue} !== 3'b010) begin errors++; $display("FAIL idle_rgb got %b exp 010", {red, green, blue}); end
  endtask

  task automatic test_pan_left();
    do_reset();
    set_keys(6'b000100);
    vnotactive = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (i == 5 || i == 99) begin
        checks++; if (originX !== 10'd298) begin errors++; $display("FAIL left_blank_%0d originX got %0d exp 298", i, originX); end
      end
    end
    vnotactive = 1'b0;
    set_keys(6'b0);
    run_frame(3, 3);
    checks++; if (originX !== 10'd298 || originY !== 10'd200) begin errors++; $display("FAIL left_after origin got %0d,%0d exp 298,200", originX, originY); end
  endtask

  task automatic test_repeat_right();
    do_reset();
    set_keys(6'b001000);
    for (int f = 1; f <= 12; f++) begin
      run_frame(3, 3);
      if (f == 1 || f == 8) begin
        checks++; if (originX !== 10'd302) begin errors++; $display("FAIL repeat_f%0d originX got %0d exp 302", f, originX); end
      end
      if (f == 9) begin
        checks++; if (originX !== 10'd304) begin errors++; $display("FAIL repeat_f9 originX got %0d exp 304", originX); end
      end
    end
    set_keys(6'b0);
    run_frame(3, 3);
    checks++; if (originX !== 10'd310) begin errors++; $display("FAIL repeat_f12 originX got %0d exp 310", originX); end
  endtask

  task automatic test_zoom_clamp();
    do_reset();
    tap(6'b010000);
    checks++; if (zoom !== 2'd1) begin errors++; $display("FAIL zoom_in1 got %0d exp 1", zoom); end
    repeat (2) tap(6'b010000);
    checks++; if (zoom !== 2'd3) begin errors++; $display("FAIL zoom_in3 got %0d exp 3", zoom); end
    repeat (22) tap(6'b001010);
    checks++; if (originX !== 10'd639 || originY !== 10'd479) begin errors++; $display("FAIL clamp_max got %0d,%0d exp 639,479", originX, originY); end
    repeat (29) tap(6'b000001);
    checks++; if (originY !== 10'd15) begin errors++; $display("FAIL up_z3 originY got %0d exp 15", originY); end
    tap(6'b100000);
    tap(6'b000001);
    checks++; if (originY !== 10'd7 || zoom !== 2'd2) begin errors++; $display("FAIL up_z2 originY,zoom got %0d,%0d exp 7,2", originY, zoom); end
    tap(6'b100000);
    tap(6'b000001);
    checks++; if (originY !== 10'd3 || zoom !== 2'd1) begin errors++; $display("FAIL up_z1 originY,zoom got %0d,%0d exp 3,1", originY, zoom); end
    tap(6'b000001);
    checks++; if (originY !== 10'd0) begin errors++; $display("FAIL clamp_zero originY got %0d exp 0", originY); end
    tap(6'b100000);
    tap(6'b000100);
    checks++; if (originX !== 10'd637 || zoom !== 2'd0) begin errors++; $display("FAIL left_637 originX,zoom got %0d,%0d exp 637,0", originX, zoom); end
    tap(6'b001000);
    checks++; if (originX !== 10'd639) begin errors++; $display("FAIL right_639 originX got %0d exp 639", originX); end
    tap(6'b001000);
    checks++; if (originX !== 10'd639) begin errors++; $display("FAIL right_hold_max originX got %0d exp 639", originX); end
  endtask

  task automatic test_priority();
    do_reset();
    tap(6'b001111);
    checks++; if (originX !== 10'd298 || originY !== 10'd198) begin errors++; $display("FAIL pan_priority got %0d,%0d exp 298,198", originX, originY); end
    tap(6'b100000);
    checks++; if (zoom !== 2'd0) begin errors++; $display("FAIL zoom_out_floor got %0d exp 0", zoom); end
    repeat (4) tap(6'b010000);
    checks++; if (zoom !== 2'd3) begin errors++; $display("FAIL zoom_sat got %0d exp 3", zoom); end
    tap(6'b110000);
    checks++; if (zoom !== 2'd3) begin errors++; $display("FAIL zoom_priority got %0d exp 3", zoom); end
  endtask

  task automatic test_mapping();
    int   n;
    exp_t e;
    n = 16;
    do_reset();
    repeat (2) tap(6'b010000);
    checks++; if (zoom !== 2'd2) begin errors++; $display("FAIL map_setup zoom got %0d exp 2", zoom); end
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        col = 10'd40; row = 10'd8; pix_in = 3'b101;
      end else begin
        col = 10'($urandom_range(0, 1023)); row = 10'($urandom_range(0, 1023));
        pix_in = 3'($urandom_range(0, 7));
      end
      vnotactive = (i == n - 1);
      e.mx  = 10'(300 + int'(col >> 2));
      e.my  = 10'(200 + int'(row >> 2));
      e.rgb = vnotactive ? 3'b000 : pix_in;
      exp_q.push_back(e);
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (map_x !== e.mx || map_y !== e.my) begin errors++; $display("FAIL map_%0d got %0d,%0d exp %0d,%0d", i, map_x, map_y, e.mx, e.my); end
        checks++; if ({red, green, blue} !== e.rgb) begin errors++; $display("FAIL rgb_%0d got %b exp %b", i, {red, green, blue}, e.rgb); end
      end
    end
    vnotactive = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_update();
    set_keys(6'b000100);
    repeat (3) run_frame(3, 3);
    checks++; if (originX !== 10'd292) begin errors++; $display("FAIL pre_reset originX got %0d exp 292", originX); end
    vnotactive = 1'b1;
    @(negedge CLK);
    RST = 1'b1; col = 10'd100; row = 10'd100; pix_in = 3'b011;
    @(negedge CLK);
    checks++; if (originX !== 10'd300 || originY !== 10'd200) begin errors++; $display("FAIL mid_reset origin got %0d,%0d exp 300,200", originX, originY); end
    checks++; if (zoom !== 2'd0) begin errors++; $display("FAIL mid_reset zoom got %0d exp 0", zoom); end
    checks++; if ({map_x, map_y} !== 20'd0 || {red, green, blue} !== 3'b111) begin errors++; $display("FAIL mid_reset map/rgb got %0d,%0d,%b exp 0,0,111", map_x, map_y, {red, green, blue}); end
    RST = 1'b0; vnotactive = 1'b0;
    repeat (2) @(negedge CLK);
    run_frame(3, 3);
    checks++; if (originX !== 10'd298) begin errors++; $display("FAIL post_reset_repeat originX got %0d exp 298", originX); end
    set_keys(6'b0);
    run_frame(3, 3);
  endtask

  initial begin
    RST = 1'b1; set_keys(6'b0); vnotactive = 1'b0;
    col = '0; row = '0; pix_in = '0;
    test_reset();
    test_pan_left();
    test_repeat_right();
    test_zoom_clamp();
    test_priority();
    test_mapping();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/viewport_ctrl.md
Name: viewport_ctrl

Overview:
- Parametrised pan/zoom viewport controller for the VGA chaos-map display.
- Sits between the sync generator (row/col/vnotactive) and the pixel generator, such as the logistic map engine.
- Maps screen coordinates to world coordinates using a button-controlled origin and zoom level.
- Registers the returned pixel colour with blanking.
- Adds over the previous single-step pan: zoom, edge clamping, hold-to-repeat, and multi-bit colour.

Parameters:
- COORD_W, 10, width of row/col, origin and map coordinates
- COLOR_BITS, 1, bits per colour channel
- STEP, 2, base pan step in world units
- X_INIT, 300, originX reset value
- Y_INIT, 200, originY reset value
- X_MAX, 639, maximum originX
- Y_MAX, 479, maximum originY
- ZOOM_MAX, 3, maximum zoom shift
- REPEAT_DELAY, 8, held frames before auto-repeat starts

Ports:
- CLK  in  1  pixel clock
- RST  in  1  synchronous active-high reset
- row  in  COORD_W  current scan row
- col  in  COORD_W  current scan column
- vnotactive  in  1  high during vertical blanking
- up, down, left, right  in  1 each  pan buttons, active-low
- zoom_in, zoom_out  in  1 each  zoom buttons, active-low
- pix_in  in  3*COLOR_BITS  {r,g,b} from pixel generator, valid 1 cycle after map_x/map_y
- map_x, map_y  out  COORD_W  world coordinate sent to the pixel generator
- originX, originY  out  COORD_W  current origin
- zoom  out  clog2(ZOOM_MAX+1)  current zoom shift
- red, green, blue  out  COLOR_BITS each  registered colour

Behaviour:
- Reset: synchronous, active-high, sampled on posedge CLK. It takes effect immediately, including mid-frame or mid-update. Reset values:
  - originX=X_INIT, originY=Y_INIT, zoom=0
  - map_x=map_y=0
  - red/green/blue all ones
  - FSM=ACTIVE
  - all repeat counters 0
- Frame FSM (states ACTIVE, UPDATE, BLANK):
  - ACTIVE -> UPDATE when vnotactive=1.
  - UPDATE lasts exactly 1 cycle, then -> BLANK.
  - BLANK -> ACTIVE when vnotactive=0.
  - Result: exactly one update per blanking interval, regardless of blanking length.
- frame_tick is high only in UPDATE. Button inputs are sampled only in that cycle.
- Repeat, per key, using a held-frame counter that saturates at REPEAT_DELAY:
  - On each frame_tick: if key is low, fire when counter==0 or counter==REPEAT_DELAY, then increment the counter (saturating).
  - If key is high, counter clears and the key does not fire.
  - Net effect: fires on the first frame, pauses, then fires every frame from the (REPEAT_DELAY+1)th held frame onward.
- Pan, applied in UPDATE:
  - step = STEP << zoom, using the zoom value before this update.
  - up has priority over down; left has priority over right.
  - X and Y are independent, so both axes can move in one update.
  - Subtraction saturates at 0.
  - Addition saturates at X_MAX / Y_MAX. Compute at COORD_W+1 bits, then clamp.
- Zoom, applied in the same UPDATE cycle as pan:
  - zoom_in increments zoom, saturating at ZOOM_MAX.
  - zoom_out decrements zoom, saturating at 0.
  - zoom_in has priority if both fire.
- Mapping, every cycle:
  - map_x <= originX + (col >> zoom); map_y <= originY + (row >> zoom).
  - Results are truncated to COORD_W (modulo wrap is allowed).
- Colour, every cycle:
  - {red,green,blue} <= vnotactive ? 0 : pix_in.
  - Latency is col/row -> map_x/map_y 1 cycle, pix_in -> rgb 1 cycle, 2 cycles total.
- Origin and zoom change only in UPDATE, so they are stable throughout active video.

Decomposition:
- Package viewport_pkg:
  - FSM state enum {ACTIVE, UPDATE, BLANK}
  - key index constants K_UP, K_DOWN, K_LEFT, K_RIGHT, K_ZIN, K_ZOUT, NUM_KEYS=6
  - a saturating add/sub function
- Sub-module key_repeat (parameter REPEAT_DELAY):
  - inputs CLK, RST, key_n, frame_tick; output fire.
  - Instantiated NUM_KEYS times.

Test Plan:
- Reset, then RST=0 with no keys pressed, over several frames -> originX=300, originY=200, zoom=0, rgb all ones until the first pixel; origin unchanged.
- left held low for 1 frame, zoom=0 -> originX=298 after that UPDATE; originX unchanged for the long blank (vnotactive high 100 cycles).
- right held 12 frames -> fires on frames 1, 9, 10, 11, 12 -> originX=310.
- zoom_in held 1 frame, then released; then up held at originY=3 -> zoom=1, step=4, originY clamps to 0 (not 1023). At originX=637 with zoom=0, right pressed -> originX=639.
- up and down both pressed; left and right both pressed -> originY-=2, originX-=2. zoom_in and zoom_out both pressed at zoom=3 -> zoom stays 3.
- zoom=2, origin (300,200), col=40, row=8, pix_in=3'b101 -> map_x=310 and map_y=202 one cycle later, rgb=101 two cycles later. RST asserted mid-UPDATE -> all reset values on the next cycle.
